// File: rtl/microsequencer_next_state.sv
// microsequencer_next_state
//   Next-state engine of the microprogrammed control unit. Holds the state
//   register that addresses the microstore and picks the next state from the
//   microstore sequencing fields, the IR opcode decoder, the memory handshake
//   and the ALU flags. Wait states (ns_sel=101) are bounded: after
//   MOC_TIMEOUT consecutive stalled edges the sequencer recovers to fetch.
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous, active-high
//   ir        instruction register, opcode = ir[31:26]
//   moc       memory operation complete
//   zero/neg  ALU flags
//   ns_sel    microstore next-state select
//   cond_sel  microstore condition select
//   inv       microstore condition invert
//   cr_addr   microstore constant (jump) address
//   state     current state (registered)
//   stalled   combinational, high while holding in a wait state
//   timeout   registered, one-cycle pulse when a wait is aborted
module microsequencer_next_state #(
    parameter int unsigned STATE_W     = 7,
    parameter int unsigned FETCH_STATE = 0,
    parameter int unsigned MAX_STATE   = 11,
    parameter int unsigned MOC_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        ir,
    input  logic               moc,
    input  logic               zero,
    input  logic               neg,
    input  logic [2:0]         ns_sel,
    input  logic [1:0]         cond_sel,
    input  logic               inv,
    input  logic [STATE_W-1:0] cr_addr,
    output logic [STATE_W-1:0] state,
    output logic               stalled,
    output logic               timeout
);

    localparam int unsigned CNT_W = 4;

    localparam logic [STATE_W-1:0] FETCH    = STATE_W'(FETCH_STATE);
    localparam logic [STATE_W-1:0] MAX_ST   = STATE_W'(MAX_STATE);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(MOC_TIMEOUT - 1);

    localparam logic [2:0] NS_DECODE  = 3'b000;
    localparam logic [2:0] NS_FETCH   = 3'b001;
    localparam logic [2:0] NS_JUMP    = 3'b010;
    localparam logic [2:0] NS_INC     = 3'b011;
    localparam logic [2:0] NS_CJUMP   = 3'b100;
    localparam logic [2:0] NS_WAIT    = 3'b101;
    localparam logic [2:0] NS_CDECODE = 3'b110;
    localparam logic [2:0] NS_FETCH2  = 3'b111;

    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               timeout_q, timeout_d;

    logic               cond_c;
    logic               wait_c;
    logic [STATE_W-1:0] decode_c;
    logic [STATE_W-1:0] state_inc_c;
    logic [STATE_W-1:0] sel_c;
    logic [STATE_W-1:0] clamp_c;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Opcode decoder; an all-zero IR is a nop even though its opcode is R-type
    always_comb begin
        decode_c = FETCH;
        if (ir != 32'h0) begin
            case (ir[31:26])
                6'b000000: decode_c = STATE_W'(10);
                6'b100011: decode_c = STATE_W'(5);
                6'b101011: decode_c = STATE_W'(7);
                6'b000100: decode_c = STATE_W'(11);
                6'b001000: decode_c = STATE_W'(6);
                6'b000010: decode_c = STATE_W'(9);
                default:   decode_c = FETCH;
            endcase
        end
    end

    // Next-state selection, clamp and wait/timeout bookkeeping
    always_comb begin
        cond_c      = 1'b0;
        sel_c       = FETCH;
        state_d     = FETCH;
        cnt_d       = '0;
        timeout_d   = 1'b0;
        state_inc_c = state_q + STATE_W'(1);

        case (cond_sel)
            2'b00:   cond_c = moc;
            2'b01:   cond_c = zero;
            2'b10:   cond_c = neg;
            default: cond_c = 1'b1;
        endcase
        cond_c = cond_c ^ inv;

        case (ns_sel)
            NS_DECODE:  sel_c = decode_c;
            NS_FETCH:   sel_c = FETCH;
            NS_JUMP:    sel_c = cr_addr;
            NS_INC:     sel_c = state_inc_c;
            NS_CJUMP:   sel_c = cond_c ? cr_addr : state_inc_c;
            NS_WAIT:    sel_c = cond_c ? state_inc_c : state_q;
            NS_CDECODE: sel_c = cond_c ? cr_addr : decode_c;
            NS_FETCH2:  sel_c = FETCH;
            default:    sel_c = FETCH;
        endcase

        // Clamp after selection, so a wrapped increment is also caught here
        clamp_c = (sel_c > MAX_ST) ? FETCH : sel_c;
        wait_c  = (ns_sel == NS_WAIT) && !cond_c;

        state_d = clamp_c;
        // A condition that becomes true on the expiring edge is not a stall,
        // so advancing always beats the timeout.
        if (wait_c) begin
            if (cnt_q == CNT_LAST) begin
                state_d   = FETCH;
                timeout_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Outputs
    always_comb begin
        state   = state_q;
        stalled = wait_c;
        timeout = timeout_q;
    end

endmodule

// File: tb/tb_microsequencer_next_state.sv
// Directed bench for microsequencer_next_state. Each step drives one cycle
// of inputs and queues the hand-computed expectation: stalled for the inputs
// just applied, and state/timeout after the following rising edge. A monitor
// pops and compares independently of the stimulus.
module tb_microsequencer_next_state;

    logic        clk;
    logic        reset;
    logic [31:0] ir;
    logic        moc, zero, neg, inv;
    logic [2:0]  ns_sel;
    logic [1:0]  cond_sel;
    logic [6:0]  cr_addr;
    logic [6:0]  state;
    logic        stalled, timeout;

    microsequencer_next_state dut (
        .clk      (clk),
        .reset    (reset),
        .ir       (ir),
        .moc      (moc),
        .zero     (zero),
        .neg      (neg),
        .ns_sel   (ns_sel),
        .cond_sel (cond_sel),
        .inv      (inv),
        .cr_addr  (cr_addr),
        .state    (state),
        .stalled  (stalled),
        .timeout  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic       stall;
        logic [6:0] st;
        logic       to;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Pending input values, applied at the next step
    logic        p_reset = 1'b1;
    logic [31:0] p_ir    = 32'h0;
    logic        p_moc   = 1'b0;
    logic        p_zero  = 1'b0;
    logic        p_neg   = 1'b0;
    logic        p_inv   = 1'b0;
    logic [2:0]  p_ns    = 3'b011;
    logic [1:0]  p_cs    = 2'b00;
    logic [6:0]  p_cr    = 7'd0;

    task automatic step(input string nm, input logic e_stall, input int e_st, input logic e_to);
        exp_t e;
        @(negedge clk);
        #1;
        reset    = p_reset;
        ir       = p_ir;
        moc      = p_moc;
        zero     = p_zero;
        neg      = p_neg;
        inv      = p_inv;
        ns_sel   = p_ns;
        cond_sel = p_cs;
        cr_addr  = p_cr;
        e.nm    = nm;
        e.stall = e_stall;
        e.st    = 7'(e_st);
        e.to    = e_to;
        q.push_back(e);
    endtask

    // Monitor: stalled checked mid-low-phase, state/timeout at the next negedge
    exp_t cur;
    bit   pend = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (pend) begin
                checks++;
                if (state !== cur.st) begin
                    errors++;
                    $display("FAIL %s state: got %0d expected %0d", cur.nm, state, cur.st);
                end
                checks++;
                if (timeout !== cur.to) begin
                    errors++;
                    $display("FAIL %s timeout: got %0b expected %0b", cur.nm, timeout, cur.to);
                end
                pend = 1'b0;
            end
            #3;
            if (q.size() > 0) begin
                cur = q.pop_front();
                checks++;
                if (stalled !== cur.stall) begin
                    errors++;
                    $display("FAIL %s stalled: got %0b expected %0b", cur.nm, stalled, cur.stall);
                end
                pend = 1'b1;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; ir = 32'h0; moc = 1'b0; zero = 1'b0; neg = 1'b0;
        inv = 1'b0; ns_sel = 3'b011; cond_sel = 2'b00; cr_addr = 7'd0;

        // Reset held two cycles with increment selected
        p_reset = 1'b1; p_ns = 3'b011;
        step("rst0", 1'b0, 0, 1'b0);
        step("rst1", 1'b0, 0, 1'b0);
        p_reset = 1'b0;
        step("inc1", 1'b0, 1, 1'b0);
        step("inc2", 1'b0, 2, 1'b0);
        step("inc3", 1'b0, 3, 1'b0);

        // Decoder
        p_ns = 3'b001; step("fetch", 1'b0, 0, 1'b0);
        p_ns = 3'b011; step("to1", 1'b0, 1, 1'b0);
        p_ns = 3'b000;
        p_ir = 32'h8C020004; step("dec_lw", 1'b0, 5, 1'b0);
        p_ir = 32'h00000000; step("dec_nop", 1'b0, 0, 1'b0);
        p_ir = 32'hFC000000; step("dec_bad", 1'b0, 0, 1'b0);
        p_ir = 32'hAC000000; step("dec_sw", 1'b0, 7, 1'b0);
        p_ir = 32'h10000000; step("dec_beq", 1'b0, 11, 1'b0);
        p_ir = 32'h20000000; step("dec_addi", 1'b0, 6, 1'b0);
        p_ir = 32'h08000000; step("dec_j", 1'b0, 9, 1'b0);
        p_ir = 32'h00221020; step("dec_rtype", 1'b0, 10, 1'b0);

        // MOC wait: three holds then advance
        p_ns = 3'b001; step("fetch2", 1'b0, 0, 1'b0);
        p_ns = 3'b011; step("to1b", 1'b0, 1, 1'b0);
        p_ns = 3'b101; p_cs = 2'b00; p_inv = 1'b0; p_moc = 1'b0;
        for (int i = 0; i < 3; i++) step("wait_hold", 1'b1, 1, 1'b0);
        p_moc = 1'b1; step("wait_go", 1'b0, 2, 1'b0);

        // MOC stuck low: timeout on the 15th stalled edge, one-cycle pulse
        p_moc = 1'b0;
        for (int i = 0; i < 14; i++) step("to_hold", 1'b1, 2, 1'b0);
        step("to_fire", 1'b1, 0, 1'b1);
        p_ns = 3'b011; step("to_clear", 1'b0, 1, 1'b0);

        // MOC arrives on the would-be expiring edge: advance wins
        p_ns = 3'b101; p_moc = 1'b0;
        for (int i = 0; i < 14; i++) step("race_hold", 1'b1, 1, 1'b0);
        p_moc = 1'b1; step("race_go", 1'b0, 2, 1'b0);
        // Counter cleared by the advance: 14 more holds stay quiet
        p_moc = 1'b0;
        for (int i = 0; i < 14; i++) step("race_rehold", 1'b1, 2, 1'b0);
        p_moc = 1'b1; step("race_go2", 1'b0, 3, 1'b0);
        p_moc = 1'b0;

        // Conditional jump on zero/neg/constant with invert
        p_ns = 3'b100; p_cs = 2'b01; p_cr = 7'd9; p_inv = 1'b0;
        p_zero = 1'b1; step("cj_z1", 1'b0, 9, 1'b0);
        p_zero = 1'b0; step("cj_z0", 1'b0, 10, 1'b0);
        p_inv = 1'b1;  step("cj_z0_inv", 1'b0, 9, 1'b0);
        p_zero = 1'b1; step("cj_z1_inv", 1'b0, 10, 1'b0);
        p_inv = 1'b0; p_cs = 2'b10; p_neg = 1'b1; step("cj_neg", 1'b0, 9, 1'b0);
        p_cs = 2'b11; step("cj_const", 1'b0, 9, 1'b0);
        p_inv = 1'b1; step("cj_const_inv", 1'b0, 10, 1'b0);
        p_inv = 1'b0; p_neg = 1'b0; p_zero = 1'b0;

        // Clamp above MAX_STATE
        p_ns = 3'b010; p_cr = 7'd12; step("clamp12", 1'b0, 0, 1'b0);
        p_cr = 7'd11; step("jump11", 1'b0, 11, 1'b0);
        p_ns = 3'b011; step("inc_clamp", 1'b0, 0, 1'b0);
        p_ns = 3'b010; p_cr = 7'd127; step("clamp127", 1'b0, 0, 1'b0);

        // Conditional decode and alternate fetch encoding
        p_ns = 3'b110; p_cs = 2'b11; p_inv = 1'b0; p_cr = 7'd3;
        step("cd_jump", 1'b0, 3, 1'b0);
        p_inv = 1'b1; p_ir = 32'h8C020004; step("cd_dec", 1'b0, 5, 1'b0);
        p_inv = 1'b0; p_ns = 3'b111; step("fetch7", 1'b0, 0, 1'b0);

        // Reset mid-wait at cnt=7 clears the counter without a pulse
        p_ns = 3'b011; step("mw_to1", 1'b0, 1, 1'b0);
        p_ns = 3'b101; p_cs = 2'b00; p_moc = 1'b0;
        for (int i = 0; i < 7; i++) step("mw_hold", 1'b1, 1, 1'b0);
        p_reset = 1'b1; step("mw_reset", 1'b1, 0, 1'b0);
        p_reset = 1'b0;
        for (int i = 0; i < 14; i++) step("mw_rehold", 1'b1, 0, 1'b0);
        p_ns = 3'b011; step("mw_exit", 1'b0, 1, 1'b0);

        @(negedge clk);
        @(negedge clk);
        #4;
        checks++;
        if (q.size() != 0 || pend) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
